// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the ALU control stage and the execute-stage ALU.
// The unit itself takes the slave view; the issuing stage takes the master view.
`timescale 1ns/1ps
interface alu_exec_unit_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int SHAMT_WIDTH = 6
);
    logic                   InValid;
    logic                   InReady;
    logic [3:0]             ALUCtrlLine;
    logic [DATA_WIDTH-1:0]  A;
    logic [DATA_WIDTH-1:0]  B;
    logic [SHAMT_WIDTH-1:0] Shamt;
    logic                   OutValid;
    logic                   OutReady;
    logic [DATA_WIDTH-1:0]  Result;
    logic                   Zero;
    logic                   Negative;
    logic                   Carry;
    logic                   Overflow;
    logic                   IllegalOp;

    modport slave (
        input  InValid, ALUCtrlLine, A, B, Shamt, OutReady,
        output InReady, OutValid, Result, Zero, Negative, Carry, Overflow, IllegalOp
    );

    modport master (
        output InValid, ALUCtrlLine, A, B, Shamt, OutReady,
        input  InReady, OutValid, Result, Zero, Negative, Carry, Overflow, IllegalOp
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Handshaked LEGv8 execute-stage ALU: one-cycle logic/arithmetic ops, bit-serial
// shifts, registered result and NZCV flags held until the consumer takes them.
`timescale 1ns/1ps
module alu_exec_unit #(
    parameter int DATA_WIDTH  = 64,
    parameter int SHAMT_WIDTH = 6
) (
    input  logic           CLK,
    input  logic           RESET,
    alu_exec_unit_if.slave aluBus
);
    localparam int MSB = DATA_WIDTH - 1;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_LSL   = 4'd3;
    localparam logic [3:0] OP_LSR   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_PASSB = 4'd7;
    localparam logic [3:0] OP_PASSX = 4'd8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]             state;
    logic [DATA_WIDTH-1:0]  workReg;
    logic [SHAMT_WIDTH-1:0] counter;
    logic                   shiftLeft;

    logic [DATA_WIDTH-1:0]  resultReg;
    logic                   zeroReg;
    logic                   negativeReg;
    logic                   carryReg;
    logic                   overflowReg;
    logic                   illegalReg;

    logic                   accept;
    logic                   opIsShift;
    logic [DATA_WIDTH:0]    sumWide;
    logic [DATA_WIDTH:0]    diffWide;
    logic [DATA_WIDTH-1:0]  singleResult;
    logic                   singleCarry;
    logic                   singleOverflow;
    logic                   singleIllegal;
    logic [DATA_WIDTH-1:0]  shiftNext;
    logic                   shiftOut;

    // RESET gates InReady directly so nothing is accepted on a reset edge.
    assign aluBus.InReady   = (state == IDLE) && !RESET;
    assign aluBus.OutValid  = (state == DONE);
    assign aluBus.Result    = resultReg;
    assign aluBus.Zero      = zeroReg;
    assign aluBus.Negative  = negativeReg;
    assign aluBus.Carry     = carryReg;
    assign aluBus.Overflow  = overflowReg;
    assign aluBus.IllegalOp = illegalReg;

    assign accept    = aluBus.InValid && aluBus.InReady;
    assign opIsShift = (aluBus.ALUCtrlLine == OP_LSL) || (aluBus.ALUCtrlLine == OP_LSR);

    // Subtraction is A + ~B + 1, so the carry-out means "no borrow".
    assign sumWide  = {1'b0, aluBus.A} + {1'b0, aluBus.B};
    assign diffWide = {1'b0, aluBus.A} + {1'b0, ~aluBus.B} + {{DATA_WIDTH{1'b0}}, 1'b1};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no
        // path through the case leaves it unassigned, which would infer a latch.
        singleResult   = '0;
        singleCarry    = 1'b0;
        singleOverflow = 1'b0;
        singleIllegal  = 1'b0;
        unique case (aluBus.ALUCtrlLine)
            OP_AND: singleResult = aluBus.A & aluBus.B;
            OP_OR:  singleResult = aluBus.A | aluBus.B;
            OP_ADD: begin
                singleResult   = sumWide[MSB:0];
                singleCarry    = sumWide[DATA_WIDTH];
                singleOverflow = (aluBus.A[MSB] == aluBus.B[MSB]) &&
                                 (sumWide[MSB] != aluBus.A[MSB]);
            end
            OP_SUB: begin
                singleResult   = diffWide[MSB:0];
                singleCarry    = diffWide[DATA_WIDTH];
                singleOverflow = (aluBus.A[MSB] != aluBus.B[MSB]) &&
                                 (diffWide[MSB] != aluBus.A[MSB]);
            end
            OP_PASSB, OP_PASSX: singleResult = aluBus.B;
            // Zero-distance shift completes immediately with A unchanged.
            OP_LSL, OP_LSR: singleResult = aluBus.A;
            default: singleIllegal = 1'b1;
        endcase
    end

    assign shiftNext = shiftLeft ? (workReg << 1) : (workReg >> 1);
    assign shiftOut  = shiftLeft ? workReg[MSB] : workReg[0];

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the values from before this edge, independent of statement order.
        if (RESET) begin
            state       <= IDLE;
            workReg     <= '0;
            counter     <= '0;
            shiftLeft   <= 1'b0;
            resultReg   <= '0;
            zeroReg     <= 1'b0;
            negativeReg <= 1'b0;
            carryReg    <= 1'b0;
            overflowReg <= 1'b0;
            illegalReg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        illegalReg <= singleIllegal;
                        if (opIsShift && (aluBus.Shamt != '0)) begin
                            state     <= SHIFT;
                            workReg   <= aluBus.A;
                            counter   <= aluBus.Shamt;
                            shiftLeft <= (aluBus.ALUCtrlLine == OP_LSL);
                        end else begin
                            state       <= DONE;
                            resultReg   <= singleResult;
                            zeroReg     <= (singleResult == '0);
                            negativeReg <= singleResult[MSB];
                            carryReg    <= singleCarry;
                            overflowReg <= singleOverflow;
                        end
                    end
                end
                SHIFT: begin
                    workReg <= shiftNext;
                    counter <= counter - SHAMT_WIDTH'(1);
                    // Result and flags are committed once, on the final step.
                    if (counter == SHAMT_WIDTH'(1)) begin
                        state       <= DONE;
                        resultReg   <= shiftNext;
                        zeroReg     <= (shiftNext == '0);
                        negativeReg <= shiftNext[MSB];
                        carryReg    <= shiftOut;
                        overflowReg <= 1'b0;
                    end
                end
                DONE: begin
                    if (aluBus.OutReady) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios from the test plan
// plus randomized traffic scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_exec_unit;
    localparam int DW = 64;
    localparam int SW = 6;

    typedef struct {
        logic [DW-1:0] res;
        logic          z, n, c, v, ill;
        int            lat;
    } expect_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    int   assertCount = 0;
    int   failCount   = 0;

    alu_exec_unit_if #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) aluBus ();

    alu_exec_unit #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .aluBus(aluBus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    function automatic logic [DW+4:0] pk(input expect_t e);
        return {e.res, e.z, e.n, e.c, e.v, e.ill};
    endfunction

    function automatic expect_t mk(input logic [DW-1:0] res, input logic z, n, c, v, ill, input int lat);
        expect_t e;
        e.res = res; e.z = z; e.n = n; e.c = c; e.v = v; e.ill = ill; e.lat = lat;
        return e;
    endfunction

    // Reference model: plain wide arithmetic, no knowledge of the unit's internals.
    function automatic expect_t model(input logic [3:0] code, input logic [DW-1:0] a, b, input int sh);
        expect_t e;
        logic signed [DW+1:0] wa, wb, wide;
        e = mk('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        wa = $signed({{2{a[DW-1]}}, a});
        wb = $signed({{2{b[DW-1]}}, b});
        case (code)
            4'd0: e.res = a & b;
            4'd1: e.res = a | b;
            4'd2: begin
                e.res = a + b;
                e.c   = (e.res < a);
                wide  = wa + wb;
                e.v   = (wide != $signed({{2{e.res[DW-1]}}, e.res}));
            end
            4'd6: begin
                e.res = a - b;
                e.c   = (a >= b);
                wide  = wa - wb;
                e.v   = (wide != $signed({{2{e.res[DW-1]}}, e.res}));
            end
            4'd7, 4'd8: e.res = b;
            4'd3: begin
                e.res = a << sh;
                if (sh != 0) e.c = a[DW-sh];
                e.lat = (sh == 0) ? 1 : sh + 1;
            end
            4'd4: begin
                e.res = a >> sh;
                if (sh != 0) e.c = a[sh-1];
                e.lat = (sh == 0) ? 1 : sh + 1;
            end
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == '0);
        e.n = e.res[DW-1];
        return e;
    endfunction

    function automatic logic [DW-1:0] rand64();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(DW-1){1'b0}}};
            3:       return {1'b0, {(DW-1){1'b1}}};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Presents one request, scrambles inputs after accept, waits (bounded) for OutValid.
    task automatic runOp(input logic [3:0] code, input logic [DW-1:0] a, b, input int sh,
                         input bit readyEarly, output bit readyAtAccept, output expect_t got);
        int cycles;
        @(negedge CLK);
        readyAtAccept      = aluBus.InReady;
        aluBus.InValid     = 1'b1;
        aluBus.ALUCtrlLine = code;
        aluBus.A           = a;
        aluBus.B           = b;
        aluBus.Shamt       = SW'(sh);
        aluBus.OutReady    = readyEarly;
        @(posedge CLK);
        @(negedge CLK);
        aluBus.InValid     = 1'b0;
        aluBus.ALUCtrlLine = 4'($urandom_range(0, 15));
        aluBus.A           = rand64();
        aluBus.B           = rand64();
        aluBus.Shamt       = SW'($urandom_range(0, 63));
        cycles = 1;
        while (!aluBus.OutValid && cycles < 200) begin
            @(negedge CLK);
            cycles++;
        end
        got = mk(aluBus.Result, aluBus.Zero, aluBus.Negative, aluBus.Carry,
                 aluBus.Overflow, aluBus.IllegalOp, cycles);
    endtask

    // Holds the result for `stall` cycles (unless OutReady already high), then retires it.
    task automatic retireOp(input int stall, output bit stable, output bit validAfter, output bit readyAfter);
        logic [DW+4:0] snap;
        snap   = {aluBus.Result, aluBus.Zero, aluBus.Negative, aluBus.Carry, aluBus.Overflow, aluBus.IllegalOp};
        stable = 1'b1;
        if (!aluBus.OutReady) begin
            repeat (stall) begin
                @(negedge CLK);
                if (!aluBus.OutValid || snap !== {aluBus.Result, aluBus.Zero, aluBus.Negative,
                                                  aluBus.Carry, aluBus.Overflow, aluBus.IllegalOp})
                    stable = 1'b0;
            end
            aluBus.OutReady = 1'b1;
        end
        @(negedge CLK);
        validAfter      = aluBus.OutValid;
        readyAfter      = aluBus.InReady;
        aluBus.OutReady = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        assertCount++;
        if ({aluBus.InReady, aluBus.OutValid} !== 2'b10) begin
            failCount++;
            $display("FAIL reset_handshake got InReady/OutValid=%b want 10", {aluBus.InReady, aluBus.OutValid});
        end
        assertCount++;
        if ({aluBus.Result, aluBus.Zero, aluBus.Negative, aluBus.Carry, aluBus.Overflow, aluBus.IllegalOp} !== '0) begin
            failCount++;
            $display("FAIL reset_outputs got res=%h zncvi=%b want all zero", aluBus.Result,
                     {aluBus.Zero, aluBus.Negative, aluBus.Carry, aluBus.Overflow, aluBus.IllegalOp});
        end
    endtask

    // Directed op with literal expectation, followed by a prompt retire.
    task automatic directedOp(input string name, input logic [3:0] code, input logic [DW-1:0] a, b,
                              input int sh, input expect_t want);
        bit rdy, stable, va, ra;
        expect_t got;
        runOp(code, a, b, sh, 1'b0, rdy, got);
        assertCount++;
        if (!rdy || got.lat !== want.lat) begin
            failCount++;
            $display("FAIL %s_latency got ready=%0d edges=%0d want ready=1 edges=%0d", name, rdy, got.lat, want.lat);
        end
        assertCount++;
        if (pk(got) !== pk(want)) begin
            failCount++;
            $display("FAIL %s_result got res=%h zncvi=%b want res=%h zncvi=%b", name,
                     got.res, {got.z, got.n, got.c, got.v, got.ill}, want.res, {want.z, want.n, want.c, want.v, want.ill});
        end
        retireOp(0, stable, va, ra);
        assertCount++;
        if ({va, ra} !== 2'b01) begin
            failCount++;
            $display("FAIL %s_retire got OutValid/InReady=%b want 01", name, {va, ra});
        end
    endtask

    task automatic test_add_overflow();
        directedOp("add_ovf", 4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0,
                   mk(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1));
    endtask

    task automatic test_sub();
        directedOp("sub_eq", 4'd6, 64'd5, 64'd5, 0, mk(64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1));
        directedOp("sub_borrow", 4'd6, 64'd3, 64'd5, 0,
                   mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1));
    endtask

    task automatic test_shift_backpressure();
        bit rdy, stable, va, ra;
        expect_t got;
        runOp(4'd3, 64'h8000_0000_0000_0001, 64'd0, 4, 1'b0, rdy, got);
        assertCount++;
        if (got.lat !== 5 || pk(got) !== pk(mk(64'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5))) begin
            failCount++;
            $display("FAIL lsl4_result got edges=%0d res=%h zncvi=%b want edges=5 res=10 zncvi=00000",
                     got.lat, got.res, {got.z, got.n, got.c, got.v, got.ill});
        end
        retireOp(3, stable, va, ra);
        assertCount++;
        if ({stable, va, ra} !== 3'b101) begin
            failCount++;
            $display("FAIL lsl4_stall got stable/OutValid/InReady=%b want 101", {stable, va, ra});
        end
        directedOp("lsr1", 4'd4, 64'h3, 64'd0, 1, mk(64'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2));
    endtask

    task automatic test_illegal_pass();
        directedOp("illegal9", 4'd9, rand64(), rand64(), 0, mk(64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1));
        directedOp("pass7", 4'd7, rand64(), 64'h1234, 0, mk(64'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1));
    endtask

    task automatic test_reset_mid_shift();
        bit sawValid;
        @(negedge CLK);
        aluBus.InValid     = 1'b1;
        aluBus.ALUCtrlLine = 4'd3;
        aluBus.A           = rand64();
        aluBus.Shamt       = SW'(63);
        aluBus.OutReady    = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        aluBus.InValid = 1'b0;
        sawValid = aluBus.OutValid;
        repeat (8) begin
            @(negedge CLK);
            sawValid |= aluBus.OutValid;
        end
        RESET = 1'b1;
        @(negedge CLK);
        sawValid |= aluBus.OutValid;
        assertCount++;
        if (aluBus.InReady !== 1'b0) begin
            failCount++;
            $display("FAIL midshift_ready_in_reset got %b want 0", aluBus.InReady);
        end
        RESET = 1'b0;
        #1;
        assertCount++;
        if (aluBus.InReady !== 1'b1 || aluBus.Result !== '0) begin
            failCount++;
            $display("FAIL midshift_after_reset got InReady=%b res=%h want InReady=1 res=0", aluBus.InReady, aluBus.Result);
        end
        repeat (70) begin
            @(negedge CLK);
            sawValid |= aluBus.OutValid;
        end
        aluBus.OutReady = 1'b0;
        assertCount++;
        if (sawValid !== 1'b0) begin
            failCount++;
            $display("FAIL midshift_no_result got OutValid seen=%b want 0", sawValid);
        end
        directedOp("add_after_reset", 4'd2, 64'd1, 64'd1, 0, mk(64'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1));
    endtask

    task automatic test_random();
        bit rdy, stable, va, ra;
        expect_t got, want;
        logic [3:0] code;
        logic [DW-1:0] a, b;
        int sh;
        for (int i = 0; i < 40; i++) begin
            code = 4'($urandom_range(0, 15));
            a    = rand64();
            b    = rand64();
            sh   = $urandom_range(0, 63);
            want = model(code, a, b, sh);
            runOp(code, a, b, sh, 1'($urandom_range(0, 1)), rdy, got);
            assertCount++;
            if (!rdy || got.lat !== want.lat || pk(got) !== pk(want)) begin
                failCount++;
                $display("FAIL random_%0d code=%0d a=%h b=%h sh=%0d got edges=%0d res=%h zncvi=%b want edges=%0d res=%h zncvi=%b",
                         i, code, a, b, sh, got.lat, got.res, {got.z, got.n, got.c, got.v, got.ill},
                         want.lat, want.res, {want.z, want.n, want.c, want.v, want.ill});
            end
            retireOp($urandom_range(0, 3), stable, va, ra);
            assertCount++;
            if ({stable, va, ra} !== 3'b101) begin
                failCount++;
                $display("FAIL random_retire_%0d got stable/OutValid/InReady=%b want 101", i, {stable, va, ra});
            end
        end
    endtask

    // Requester keeps InValid high and consumer keeps OutReady high; results must come
    // back in order with no op lost or duplicated.
    task automatic test_back_to_back();
        expect_t q[$];
        expect_t got, want;
        int sh;
        aluBus.OutReady = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge CLK);
            if (aluBus.OutValid) begin
                got = mk(aluBus.Result, aluBus.Zero, aluBus.Negative, aluBus.Carry,
                         aluBus.Overflow, aluBus.IllegalOp, 0);
                assertCount++;
                if (q.size() == 0) begin
                    failCount++;
                    $display("FAIL b2b_unexpected got res=%h want no result", got.res);
                end else begin
                    want = q.pop_front();
                    if (pk(got) !== pk(want)) begin
                        failCount++;
                        $display("FAIL b2b_result got res=%h zncvi=%b want res=%h zncvi=%b",
                                 got.res, {got.z, got.n, got.c, got.v, got.ill},
                                 want.res, {want.z, want.n, want.c, want.v, want.ill});
                    end
                end
            end
            if (cyc < 70 && aluBus.InReady) begin
                sh = $urandom_range(0, 7);
                aluBus.InValid     = 1'b1;
                aluBus.ALUCtrlLine = 4'($urandom_range(0, 15));
                aluBus.A           = rand64();
                aluBus.B           = rand64();
                aluBus.Shamt       = SW'(sh);
                q.push_back(model(aluBus.ALUCtrlLine, aluBus.A, aluBus.B, sh));
            end else if (cyc >= 70) begin
                aluBus.InValid = 1'b0;
            end
        end
        aluBus.OutReady = 1'b0;
        assertCount++;
        if (q.size() != 0) begin
            failCount++;
            $display("FAIL b2b_drain got %0d outstanding want 0", q.size());
        end
    endtask

    initial begin
        aluBus.InValid     = 1'b0;
        aluBus.ALUCtrlLine = '0;
        aluBus.A           = '0;
        aluBus.B           = '0;
        aluBus.Shamt       = '0;
        aluBus.OutReady    = 1'b0;
        test_reset();
        test_add_overflow();
        test_sub();
        test_shift_backpressure();
        test_illegal_pass();
        test_reset_mid_shift();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
